// File: rtl/adc_deser_pkg.sv
// Shared definitions for the multi-lane serial ADC capture engine.
// Frame FSM encodings plus width and lane-slice helpers.
package adc_deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_ACC   = 2'd3
  } state_e;

  function automatic int out_width(input int dw, input int avg_max);
    return dw + avg_max;
  endfunction

  function automatic int lane_lo(input int k, input int ow);
    return k * ow;
  endfunction

endpackage

// File: rtl/adc_deser_accum_lane.sv
// One SDO lane: MSB-first shift register, sign extension and
// block accumulator with a held output register.
module adc_lane_accum
  import adc_deser_pkg::*;
#(
  parameter int DW = 18,
  parameter int OW = out_width(18, 4)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_sdo,
  input  logic          i_shift,
  input  logic          i_acc,
  input  logic          i_last,
  input  logic          i_clr,
  output logic [OW-1:0] o_data
);

  logic [DW-1:0]        r_sr;
  logic signed [OW-1:0] r_acc;
  logic [OW-1:0]        r_data;
  logic signed [OW-1:0] w_sext;
  logic signed [OW-1:0] w_sum;

  assign w_sext = OW'($signed(r_sr));
  assign w_sum  = r_acc + w_sext;
  assign o_data = r_data;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_sr   <= '0;
      r_acc  <= '0;
      r_data <= '0;
    end else begin
      if (i_shift)
        r_sr <= {r_sr[DW-2:0], i_sdo};
      if (i_acc) begin
        if (i_last) begin
          r_data <= w_sum;
          r_acc  <= '0;
        end else begin
          r_acc  <= w_sum;
        end
      end else if (i_clr) begin
        r_acc <= '0;
      end
    end
  end

endmodule

// File: rtl/adc_deser_accum.sv
// AD4003-family multi-lane serial capture: shared frame FSM,
// start-latency skip, block averaging, frame count and overrun.
module adc_deser_accum
  import adc_deser_pkg::*;
#(
  parameter int ADC_LANES      = 4,
  parameter int ADC_DATA_WIDTH = 18,
  parameter int SKIP_BITS      = 0,
  parameter int AVG_LOG2_MAX   = 4,
  parameter int OUT_WIDTH      = out_width(ADC_DATA_WIDTH, AVG_LOG2_MAX),
  parameter int TCQ            = 1
) (
  input  logic                           adc_read_clk,
  input  logic                           rstn,
  input  logic                           reader_en_sync,
  input  logic                           capture_en,
  input  logic [2:0]                     avg_log2,
  input  logic                           overrun_clr,
  input  logic [ADC_LANES-1:0]           adc_sdo,
  output logic [OUT_WIDTH*ADC_LANES-1:0] adc_data_arr,
  output logic                           adc_data_valid,
  output logic [15:0]                    frame_cnt,
  output logic                           busy,
  output logic                           overrun
);

  if (TCQ < 0) begin : g_bad_tcq
    $error("TCQ must be non-negative");
  end
  if (SKIP_BITS < 0 || SKIP_BITS > 15) begin : g_bad_skip
    $error("SKIP_BITS out of range");
  end
  if (ADC_DATA_WIDTH < 16 || ADC_DATA_WIDTH > 20) begin : g_bad_dw
    $error("ADC_DATA_WIDTH out of range");
  end

  localparam logic [3:0] SKIP_LOAD = 4'(SKIP_BITS - 1);
  localparam logic [4:0] BIT_LAST  = 5'(ADC_DATA_WIDTH - 1);

  state_e     r_state;
  state_e     w_state_nxt;
  logic       w_start;
  logic [3:0] r_skip;
  logic [4:0] r_bit;
  logic [7:0] r_blk;
  logic [2:0] r_avg;
  logic       r_valid;
  logic [15:0] r_frame;
  logic       r_ovr;
  logic [2:0] w_avg_req;
  logic [2:0] w_avg_cur;
  logic [7:0] w_blk_top;
  logic       w_last;
  logic       w_shift;
  logic       w_acc;
  logic       w_clr;

  always_ff @(posedge adc_read_clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (reader_en_sync && capture_en) begin
          w_start     = 1'b1;
          w_state_nxt = (SKIP_BITS == 0) ? ST_SHIFT : ST_SKIP;
        end
      end
      ST_SKIP:
        if (r_skip == 4'd0) w_state_nxt = ST_SHIFT;
      ST_SHIFT:
        if (r_bit == BIT_LAST) w_state_nxt = ST_ACC;
      ST_ACC:
        w_state_nxt = ST_IDLE;
      default:
        w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_shift = (r_state == ST_SHIFT);
  assign w_acc   = (r_state == ST_ACC);
  assign w_clr   = (r_state == ST_IDLE) && !capture_en;

  // Block size follows the input only at the first frame of a block.
  assign w_avg_req = (int'(avg_log2) > AVG_LOG2_MAX) ?
                     3'(AVG_LOG2_MAX) : avg_log2;
  assign w_avg_cur = (r_blk == 8'd0) ? w_avg_req : r_avg;
  assign w_blk_top = 8'((9'd1 << w_avg_cur) - 9'd1);
  assign w_last    = (r_blk == w_blk_top);

  always_ff @(posedge adc_read_clk) begin
    if (!rstn) begin
      r_skip <= '0;
      r_bit  <= '0;
    end else begin
      if (w_start)
        r_skip <= SKIP_LOAD;
      else if (r_state == ST_SKIP)
        r_skip <= r_skip - 4'd1;
      if (w_shift) r_bit <= r_bit + 5'd1;
      else         r_bit <= '0;
    end
  end

  always_ff @(posedge adc_read_clk) begin
    if (!rstn) begin
      r_blk   <= '0;
      r_avg   <= '0;
      r_valid <= 1'b0;
      r_frame <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_valid <= w_acc && w_last;
      if (w_acc) begin
        if (r_blk == 8'd0) r_avg <= w_avg_req;
        if (w_last) begin
          r_blk   <= '0;
          r_frame <= r_frame + 16'd1;
        end else begin
          r_blk   <= r_blk + 8'd1;
        end
      end else if (w_clr) begin
        r_blk <= '0;
      end
      if (reader_en_sync && r_state != ST_IDLE)
        r_ovr <= 1'b1;
      else if (overrun_clr)
        r_ovr <= 1'b0;
    end
  end

  assign adc_data_valid = r_valid;
  assign frame_cnt      = r_frame;
  assign busy           = (r_state != ST_IDLE);
  assign overrun        = r_ovr;

  for (genvar k = 0; k < ADC_LANES; k++) begin : g_lane
    adc_lane_accum #(
      .DW (ADC_DATA_WIDTH),
      .OW (OUT_WIDTH)
    ) u_lane (
      .i_clk   (adc_read_clk),
      .i_rstn  (rstn),
      .i_sdo   (adc_sdo[k]),
      .i_shift (w_shift),
      .i_acc   (w_acc),
      .i_last  (w_last),
      .i_clr   (w_clr),
      .o_data  (adc_data_arr[lane_lo(k, OUT_WIDTH) +: OUT_WIDTH])
    );
  end

endmodule

// File: tb/tb_adc_deser_accum.sv
// Scoreboard bench for adc_deser_accum: 4 lanes, 18-bit, skip 2.
module tb_adc_deser_accum;

  localparam int L  = 4;
  localparam int W  = 18;
  localparam int SK = 2;
  localparam int OW = 22;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          reader_en_sync = 1'b0;
  logic          capture_en = 1'b1;
  logic [2:0]    avg_log2 = 3'd0;
  logic          overrun_clr = 1'b0;
  logic [L-1:0]  adc_sdo = '0;
  logic [OW*L-1:0] adc_data_arr;
  logic          adc_data_valid;
  logic [15:0]   frame_cnt;
  logic          busy;
  logic          overrun;

  adc_deser_accum #(
    .ADC_LANES      (L),
    .ADC_DATA_WIDTH (W),
    .SKIP_BITS      (SK),
    .AVG_LOG2_MAX   (4),
    .TCQ            (1)
  ) dut (
    .adc_read_clk   (clk),
    .rstn           (rstn),
    .reader_en_sync (reader_en_sync),
    .capture_en     (capture_en),
    .avg_log2       (avg_log2),
    .overrun_clr    (overrun_clr),
    .adc_sdo        (adc_sdo),
    .adc_data_arr   (adc_data_arr),
    .adc_data_valid (adc_data_valid),
    .frame_cnt      (frame_cnt),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW*L-1:0] data;
    logic [15:0]     fc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_fc = 16'd0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [OW*L-1:0] pk(input logic [OW-1:0] a,
      input logic [OW-1:0] b, input logic [OW-1:0] c,
      input logic [OW-1:0] d);
    return {d, c, b, a};
  endfunction

  always @(negedge clk) begin
    if (adc_data_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_data", 128'(adc_data_arr), 128'(e.data));
        chk("strobe_fcnt", 128'(frame_cnt), 128'(e.fc));
      end
    end
  end

  // One frame; ovr_at: shift index (0..W-1) or W for the ACC cycle.
  task automatic frame(input logic [W-1:0] l0, input logic [W-1:0] l1,
      input logic [W-1:0] l2, input logic [W-1:0] l3,
      input bit last, input logic [OW*L-1:0] exp_data,
      input int ovr_at, input int rst_at);
    logic [L-1:0][W-1:0] d;
    bit was_rst = 0;
    exp_t e;
    d = {l3, l2, l1, l0};
    if (last && rst_at < 0) begin
      exp_fc = exp_fc + 16'd1;
      e.data = exp_data;
      e.fc   = exp_fc;
      sb.push_back(e);
    end
    @(negedge clk);
    reader_en_sync = 1'b1;
    @(negedge clk);
    reader_en_sync = 1'b0;
    repeat (SK) @(negedge clk);
    for (int i = 0; i < W; i++) begin
      for (int k = 0; k < L; k++) adc_sdo[k] = d[k][W-1-i];
      if (i == ovr_at) reader_en_sync = 1'b1;
      if (i == rst_at) rstn = 1'b0;
      @(negedge clk);
      reader_en_sync = 1'b0;
      if (i == rst_at) begin
        rstn = 1'b1;
        was_rst = 1;
        exp_fc = 16'd0;
        chk("rst_mid_data", 128'(adc_data_arr), 128'd0);
        chk("rst_mid_fcnt", 128'(frame_cnt), 128'd0);
        chk("rst_mid_busy", 128'(busy), 128'd0);
        chk("rst_mid_ovr", 128'(overrun), 128'd0);
        chk("rst_mid_valid", 128'(adc_data_valid), 128'd0);
      end
    end
    if (ovr_at == W) reader_en_sync = 1'b1;
    @(negedge clk);
    reader_en_sync = 1'b0;
    adc_sdo = '0;
    if (!was_rst)
      chk("acc_strobe", 128'(adc_data_valid), 128'(last));
    chk("idle_after_acc", 128'(busy), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", 128'(adc_data_arr), 128'd0);
    chk("rst_valid", 128'(adc_data_valid), 128'd0);
    chk("rst_fcnt", 128'(frame_cnt), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ovr", 128'(overrun), 128'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single frame, raw sign-extended output
    avg_log2 = 3'd0;
    frame(18'h2ABCD, 18'h00005, 18'h3FFFF, 18'h1FFFF, 1,
          pk(22'h3EABCD, 22'h000005, 22'h3FFFFF, 22'h01FFFF), -1, -1);

    // Block of 4; avg change mid-block is ignored
    avg_log2 = 3'd2;
    frame(18'd100, 18'd5, 18'h3FFFF, 18'h1FFFF, 0, '0, -1, -1);
    avg_log2 = 3'd0;
    frame(18'd100, 18'd5, 18'h3FFFF, 18'h1FFFF, 0, '0, -1, -1);
    frame(18'd102, 18'd5, 18'h3FFFF, 18'h1FFFF, 0, '0, -1, -1);
    frame(18'd102, 18'd5, 18'h3FFFF, 18'h1FFFF, 1,
          pk(22'h000194, 22'h000014, 22'h3FFFFC, 22'h07FFFC), -1, -1);

    // Start during SHIFT cycle 5
    frame(18'h00123, 18'h0, 18'h0, 18'h0, 1,
          pk(22'h000123, 22'h0, 22'h0, 22'h0), 5, -1);
    chk("ovr_set", 128'(overrun), 128'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr_clr", 128'(overrun), 128'd0);

    // Start in the ACC cycle counts as overrun only
    frame(18'h00077, 18'h0, 18'h0, 18'h0, 1,
          pk(22'h000077, 22'h0, 22'h0, 22'h0), W, -1);
    chk("ovr_acc", 128'(overrun), 128'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;

    // capture_en low in IDLE discards a partial block
    avg_log2 = 3'd2;
    frame(18'd7, 18'd7, 18'd0, 18'd0, 0, '0, -1, -1);
    frame(18'd7, 18'd7, 18'd0, 18'd0, 0, '0, -1, -1);
    capture_en = 1'b0;
    @(negedge clk);
    capture_en = 1'b1;
    for (int f = 0; f < 4; f++)
      frame(18'd1, 18'd2, 18'd0, 18'd0, f == 3,
            pk(22'h4, 22'h8, 22'h0, 22'h0), -1, -1);

    // Reset during SHIFT cycle 10, then a clean frame
    avg_log2 = 3'd0;
    frame(18'h3AAAA, 18'h1, 18'h1, 18'h1, 0, '0, -1, 10);
    frame(18'h00001, 18'h0, 18'h0, 18'h0, 1,
          pk(22'h000001, 22'h0, 22'h0, 22'h0), -1, -1);

    // avg_log2=7 clamps to 16-frame blocks
    avg_log2 = 3'd7;
    for (int f = 0; f < 16; f++)
      frame(18'd1, 18'h3FFFF, 18'd3, 18'd0, f == 15,
            pk(22'h000010, 22'h3FFFF0, 22'h000030, 22'h0), -1, -1);

    repeat (4) @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
